// File: rtl/recon_stream_if.sv
// Frame-in / pixel-stream-out bundle for recon_stream_out.
// master = the output stage itself, slave = the surrounding logic.
interface recon_stream_if #(
  parameter int DW    = 20,
  parameter int NPIX  = 9,
  parameter int CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NPIX*DW-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [7:0]           out_pix8;
  logic                 out_bit;
  logic [3:0]           out_idx;
  logic                 out_last;
  logic                 frame_done;
  logic [NPIX-1:0]      frame_mask;
  logic [3:0]           frame_ones;
  logic [CNT_W-1:0]     frame_cnt;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_pix8, out_bit, out_idx, out_last,
           frame_done, frame_mask, frame_ones, frame_cnt
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_pix8, out_bit, out_idx, out_last,
           frame_done, frame_mask, frame_ones, frame_cnt
  );
endinterface

// File: rtl/recon_stream_out.sv
// Captures a 3x3 frame of Q3.16 samples, clamps to [0,1.0] and streams one pixel per beat.
// First beat the cycle after capture; out_ready low stalls the beat, in_ready low while streaming.
module recon_stream_out #(
  parameter int DW    = 20,
  parameter int FRAC  = 16,
  parameter int NPIX  = 9,
  parameter int CNT_W = 16,
  parameter logic signed [DW-1:0] THRESH = 20'sh08000
) (
  input  logic           clk,
  input  logic           rst,
  recon_stream_if.master io
);

  localparam logic signed [DW-1:0] ONE = {{(DW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [3:0] LAST = 4'(NPIX - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t               state_q, state_d;
  logic signed [DW-1:0] buf_q [NPIX];
  logic [3:0]           idx_q, idx_d;
  logic signed [DW-1:0] data_q, data_d;
  logic [7:0]           pix8_q;
  logic                 bit_q;
  logic                 done_q;
  logic [NPIX-1:0]      mask_q, mask_d;
  logic [3:0]           ones_q, ones_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 in_fire, out_fire, last_fire;

  function automatic logic signed [DW-1:0] clamp(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] r;
    if (v[DW-1])      r = '0;
    else if (v > ONE) r = ONE;
    else              r = v;
    return r;
  endfunction

  function automatic logic [7:0] quant(input logic signed [DW-1:0] c);
    return (c == ONE) ? 8'hFF : c[FRAC-1:FRAC-8];
  endfunction

  function automatic logic over_thresh(input logic signed [DW-1:0] c);
    return c >= THRESH;
  endfunction

  assign in_fire   = io.in_valid & io.in_ready;
  assign out_fire  = io.out_valid & io.out_ready;
  assign last_fire = out_fire & io.out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire)   state_d = STREAM;
      STREAM:  if (last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state_q == IDLE);
    io.out_valid = (state_q == STREAM);
    io.out_last  = (state_q == STREAM) && (idx_q == LAST);
  end

  // Beat registers hold their value unless a new frame lands or the current beat is taken.
  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    if (in_fire) begin
      idx_d  = '0;
      data_d = clamp(io.in_data[DW-1:0]);
    end else if (last_fire) begin
      idx_d  = '0;
      data_d = '0;
    end else if (out_fire) begin
      idx_d  = idx_q + 4'd1;
      data_d = buf_q[idx_d];
    end
  end

  always_comb begin
    mask_d = '0;
    ones_d = '0;
    for (int i = 0; i < NPIX; i++) begin
      mask_d[i] = over_thresh(buf_q[i]);
      ones_d    = ones_d + {3'b000, mask_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPIX; i++) begin
        buf_q[i] <= '0;
      end
      idx_q  <= '0;
      data_q <= '0;
      pix8_q <= '0;
      bit_q  <= 1'b0;
      done_q <= 1'b0;
      mask_q <= '0;
      ones_q <= '0;
      cnt_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
      pix8_q <= quant(data_d);
      bit_q  <= over_thresh(data_d);
      done_q <= last_fire;
      if (in_fire) begin
        for (int i = 0; i < NPIX; i++) begin
          buf_q[i] <= clamp(io.in_data[i*DW +: DW]);
        end
      end
      if (last_fire) begin
        mask_q <= mask_d;
        ones_q <= ones_d;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign io.out_data   = data_q;
  assign io.out_pix8   = pix8_q;
  assign io.out_bit    = bit_q;
  assign io.out_idx    = idx_q;
  assign io.frame_done = done_q;
  assign io.frame_mask = mask_q;
  assign io.frame_ones = ones_q;
  assign io.frame_cnt  = cnt_q;

endmodule
